// File: rtl/exe_div_stage.sv
// ----------------------------------------------------------------------------
// exe_div_stage
//   Execute stage with a ready-go handshake and an iterative divider.
//   - DIV/DIVU: WIDTH-cycle restoring radix-2 division. The quotient goes to
//     result_lo and the remainder to result_hi.
//   - Any other op: alu_result plus the sideband payload are registered into
//     the EXE->MEM register in one cycle.
//   - exe_allowin stalls the ID stage while a division is in flight.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   exe_valid_in   ID->EXE register holds a valid instruction
//   is_div         instruction is DIV/DIVU
//   is_signed      1 = DIV, 0 = DIVU
//   src_a, src_b   dividend / divisor
//   alu_result     result of non-divide ops
//   payload_in     sideband (PC, RegWaddr, ctrl), held stable while stalled
//   flush          exception/interrupt flush
//   mem_allowin    MEM stage can accept
//   exe_allowin    EXE can accept a new instruction from ID
//   exe_busy       divider FSM is not IDLE
//   exe_valid_out  EXE->MEM register valid
//   result_lo      quotient or alu_result
//   result_hi      remainder or 0
//   div_by_zero    committed divide had a zero divisor
//   payload_out    registered payload_in
// ----------------------------------------------------------------------------
module exe_div_stage #(
    parameter int WIDTH     = 32,
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exe_valid_in,
    input  logic                 is_div,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [PAYLOAD_W-1:0] payload_in,
    input  logic                 flush,
    input  logic                 mem_allowin,
    output logic                 exe_allowin,
    output logic                 exe_busy,
    output logic                 exe_valid_out,
    output logic [WIDTH-1:0]     result_lo,
    output logic [WIDTH-1:0]     result_hi,
    output logic                 div_by_zero,
    output logic [PAYLOAD_W-1:0] payload_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CNT_W = $clog2(WIDTH + 1);

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Divider state
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder (always < divisor)
    logic [WIDTH-1:0] quo_q, quo_d;    // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;    // divisor magnitude
    logic             qneg_q, qneg_d;  // negate quotient at the end
    logic             rneg_q, rneg_d;  // negate remainder at the end
    logic             dzp_q, dzp_d;    // pending divide-by-zero flag

    // EXE->MEM register
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 dz_q, dz_d;
    logic [PAYLOAD_W-1:0] pl_q, pl_d;

    logic             readygo, commit, start;
    logic [WIDTH-1:0] abs_a, abs_b, div_lo, div_hi;
    logic [WIDTH:0]   rem_sh;
    logic             fits;

    assign readygo = ~is_div | (state_q == S_DONE);
    assign commit  = exe_valid_in & readygo & mem_allowin & ~flush;
    assign start   = exe_valid_in & is_div & ~flush & (state_q == S_IDLE);

    assign exe_allowin   = ~exe_valid_in | (readygo & mem_allowin);
    assign exe_busy      = (state_q != S_IDLE);
    assign exe_valid_out = valid_q;
    assign result_lo     = lo_q;
    assign result_hi     = hi_q;
    assign div_by_zero   = dz_q;
    assign payload_out   = pl_q;

    // Operand magnitudes: only signed divides take absolute values.
    // |MIN| stays 2^(WIDTH-1), which is correct as an unsigned magnitude.
    assign abs_a = (is_signed & src_a[WIDTH-1]) ? negate(src_a) : src_a;
    assign abs_b = (is_signed & src_b[WIDTH-1]) ? negate(src_b) : src_b;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign fits   = (rem_sh >= {1'b0, dvs_q});

    // Sign fix-up wraps, so MIN / -1 yields quotient MIN with no trap.
    assign div_lo = qneg_q ? negate(quo_q) : quo_q;
    assign div_hi = rneg_q ? negate(rem_q) : rem_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dzp_d   = dzp_q;

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dvs_d  = abs_b;
                        quo_d  = abs_a;
                        rem_d  = '0;
                        qneg_d = is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        rneg_d = is_signed & src_a[WIDTH-1];
                        dzp_d  = 1'b0;
                        cnt_d  = CNT_W'(WIDTH);
                        state_d = S_BUSY;
                        if (src_b == '0) begin
                            // Zero divisor: skip iteration, report raw operands.
                            quo_d   = '1;
                            rem_d   = src_a;
                            qneg_d  = 1'b0;
                            rneg_d  = 1'b0;
                            dzp_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    if (fits) begin
                        rem_d = WIDTH'(rem_sh - {1'b0, dvs_q});
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_DONE;
                end
                S_DONE: begin
                    if (commit) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        dz_d = dz_q;
        pl_d = pl_q;

        // Holding valid while MEM is stalled keeps the output until consumed.
        if (flush)            valid_d = 1'b0;
        else if (commit)      valid_d = 1'b1;
        else if (mem_allowin) valid_d = 1'b0;
        else                  valid_d = valid_q;

        if (commit) begin
            pl_d = payload_in;
            if (is_div) begin
                lo_d = div_lo;
                hi_d = div_hi;
                dz_d = dzp_q;
            end else begin
                lo_d = alu_result;
                hi_d = '0;
                dz_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dzp_q   <= 1'b0;
            valid_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            dz_q    <= 1'b0;
            pl_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dzp_q   <= dzp_d;
            valid_q <= valid_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dz_q    <= dz_d;
            pl_q    <= pl_d;
        end
    end

endmodule

// File: tb/tb_exe_div_stage.sv
// ----------------------------------------------------------------------------
// tb_exe_div_stage
//   Directed-vector bench for exe_div_stage (WIDTH=32, PAYLOAD_W=64).
//   The driver pushes each expected commit into a queue; a monitor pops and
//   compares whenever MEM takes an output (exe_valid_out & mem_allowin).
// ----------------------------------------------------------------------------
module tb_exe_div_stage;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        logic [63:0] pl;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        exe_valid_in;
    logic        is_div;
    logic        is_signed;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic [63:0] payload_in;
    logic        flush;
    logic        mem_allowin;
    logic        exe_allowin;
    logic        exe_busy;
    logic        exe_valid_out;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        div_by_zero;
    logic [63:0] payload_out;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    logic [63:0] last_pl = '0;

    exe_div_stage #(.WIDTH(32), .PAYLOAD_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .exe_valid_in (exe_valid_in),
        .is_div       (is_div),
        .is_signed    (is_signed),
        .src_a        (src_a),
        .src_b        (src_b),
        .alu_result   (alu_result),
        .payload_in   (payload_in),
        .flush        (flush),
        .mem_allowin  (mem_allowin),
        .exe_allowin  (exe_allowin),
        .exe_busy     (exe_busy),
        .exe_valid_out(exe_valid_out),
        .result_lo    (result_lo),
        .result_hi    (result_hi),
        .div_by_zero  (div_by_zero),
        .payload_out  (payload_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: an output is consumed at the next edge when valid & mem_allowin.
    always @(negedge clk) begin
        exp_t e;
        if (rst && exe_valid_out && mem_allowin) begin
            if (sb.size() == 0) begin
                check("unexpected_commit", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_lo", result_lo, e.lo);
                check("sb_hi", result_hi, e.hi);
                check("sb_dz", div_by_zero, e.dz);
                check("sb_payload", payload_out, e.pl);
            end
        end
        if (rst && exe_busy && !exe_valid_in && !flush)
            check("valid_in_dropped_while_busy", 1, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [31:0] lo, hi, input logic dz, input logic [63:0] pl);
        exp_t e;
        e.lo = lo; e.hi = hi; e.dz = dz; e.pl = pl;
        sb.push_back(e);
    endtask

    task automatic drive(input logic div, sgn, input logic [31:0] a, b, alu, input logic [63:0] pl);
        exe_valid_in = 1'b1;
        is_div       = div;
        is_signed    = sgn;
        src_a        = a;
        src_b        = b;
        alu_result   = alu;
        payload_in   = pl;
    endtask

    // Issue one op, wait for exe_allowin, and let it commit on the next edge.
    // exp_cyc is the number of edges before the commit edge.
    task automatic run_op(input string name, input logic div, sgn,
                          input logic [31:0] a, b, alu, input logic [63:0] pl,
                          input logic [31:0] elo, ehi, input logic edz,
                          input int exp_cyc);
        int cyc = 0;
        push_exp(elo, ehi, edz, pl);
        mem_allowin = 1'b1;
        drive(div, sgn, a, b, alu, pl);
        #1;
        while (!exe_allowin && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
        @(posedge clk); #1;
        check({name, "_valid_out"}, exe_valid_out, 1);
        last_pl = pl;
    endtask

    task automatic idle();
        exe_valid_in = 1'b0;
        is_div       = 1'b0;
        mem_allowin  = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; exe_valid_in = 1'b0; is_div = 1'b0; is_signed = 1'b0;
        src_a = '0; src_b = '0; alu_result = '0; payload_in = '0;
        flush = 1'b0; mem_allowin = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out", exe_valid_out, 0);
        check("rst_busy", exe_busy, 0);
        check("rst_lo", result_lo, 0);
        check("rst_hi", result_hi, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_payload", payload_out, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Back-to-back stream of non-div and div ops
        run_op("add0",     0, 0, 32'd0, 32'd0, 32'h0000_1234, 64'hA000_0000_0000_0001,
               32'h0000_1234, 32'h0, 0, 0);
        run_op("divu_100_7", 1, 0, 32'd100, 32'd7, 32'hDEAD_BEEF, 64'hA000_0000_0000_0002,
               32'd14, 32'd2, 0, 33);
        run_op("div_m7_2", 1, 1, 32'hFFFF_FFF9, 32'd2, 32'h0, 64'hA000_0000_0000_0003,
               32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 33);
        run_op("div_min_m1", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 64'hA000_0000_0000_0004,
               32'h8000_0000, 32'h0, 0, 33);
        run_op("div_100_m7", 1, 1, 32'd100, 32'hFFFF_FFF9, 32'h0, 64'hA000_0000_0000_0005,
               32'hFFFF_FFF2, 32'd2, 0, 33);
        run_op("divu_5_0", 1, 0, 32'd5, 32'd0, 32'h0, 64'hA000_0000_0000_0006,
               32'hFFFF_FFFF, 32'd5, 1, 1);
        run_op("add_after_dz", 0, 0, 32'd0, 32'd0, 32'h0000_CAFE, 64'hA000_0000_0000_0007,
               32'h0000_CAFE, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_op("b2b", 0, 0, 32'd0, 32'd0, 32'h1111_0000 + 32'(i),
                   64'hB000_0000_0000_0000 + 64'(i),
                   32'h1111_0000 + 32'(i), 32'h0, 0, 0);
        end
        idle();

        // MEM stall through BUSY and 5 cycles into DONE
        mem_allowin = 1'b0;
        drive(1, 0, 32'd1000, 32'd7, 32'h0, 64'hC000_0000_0000_00AA);
        repeat (33 + 5) begin
            @(posedge clk); #1;
        end
        check("hold_valid_out", exe_valid_out, 0);
        check("hold_payload", payload_out, last_pl);
        check("hold_busy", exe_busy, 1);
        check("hold_allowin", exe_allowin, 0);
        push_exp(32'd142, 32'd6, 0, 64'hC000_0000_0000_00AA);
        mem_allowin = 1'b1;
        #1;
        check("release_allowin", exe_allowin, 1);
        @(posedge clk); #1;
        check("release_valid_out", exe_valid_out, 1);
        idle();

        // Flush in the middle of a division
        drive(1, 0, 32'd100, 32'd7, 32'h0, 64'hD000_0000_0000_0001);
        repeat (11) begin
            @(posedge clk); #1;
        end
        check("pre_flush_busy", exe_busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", exe_busy, 0);
        check("flush_valid_out", exe_valid_out, 0);
        run_op("add_after_flush", 0, 0, 32'd0, 32'd0, 32'h0000_0077, 64'hD000_0000_0000_0002,
               32'h0000_0077, 32'h0, 0, 0);
        idle();

        // Asynchronous reset in the middle of a division
        drive(1, 0, 32'd100, 32'd7, 32'h0, 64'hE000_0000_0000_0001);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #2;
        check("midrst_valid_out", exe_valid_out, 0);
        check("midrst_busy", exe_busy, 0);
        check("midrst_lo", result_lo, 0);
        check("midrst_hi", result_hi, 0);
        check("midrst_dz", div_by_zero, 0);
        check("midrst_payload", payload_out, 0);
        exe_valid_in = 1'b0;
        is_div = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
